// File: rtl/nic_eject_port.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nic_eject_port: per-VC ejection FIFOs, round-robin eject, credit return.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module nic_eject_port #(
  parameter int NUM_VC = 4,
  parameter int DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           in_cycle,
  input  logic [21:0]           flit_in,
  output logic                  eject_valid,
  output logic [4:0]            eject_vc,
  output logic [15:0]           eject_data,
  input  logic                  eject_ready,
  output logic [21:0]           cr_out,
  output logic [NUM_VC*4-1:0]   occupancy,
  output logic                  overflow
);

  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int VIW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  logic [15:0]     mem   [NUM_VC][DEPTH];
  logic [PW-1:0]   head  [NUM_VC];
  logic [PW-1:0]   tail  [NUM_VC];
  logic [CW-1:0]   count [NUM_VC];
  logic [VIW-1:0]  rr_ptr;
  logic [VIW-1:0]  sel;
  logic            any;
  logic            pop;
  logic            drop;
  logic [NUM_VC-1:0] push_en;
  logic [NUM_VC-1:0] pop_en;
  int              idx;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  // Round-robin scan from rr_ptr upward with wrap; first non-empty VC wins.
  always_comb begin
    any = 1'b0;
    sel = '0;
    idx = 0;
    for (int k = 0; k < NUM_VC; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_VC) idx = idx - NUM_VC;
      if (!any && count[idx] != '0) begin
        any = 1'b1;
        sel = VIW'(idx);
      end
    end
  end

  assign pop         = any && eject_ready;
  assign eject_valid = any;
  assign eject_vc    = any ? 5'(sel) : 5'd0;
  assign eject_data  = any ? mem[sel][head[sel]] : 16'd0;

  // Full check uses the pre-edge count, so a pop cannot make room for a same-cycle push.
  always_comb begin
    push_en = '0;
    pop_en  = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      push_en[v] = flit_in[21] && (flit_in[20:16] == 5'(v)) && (count[v] != C_FULL);
      pop_en[v]  = pop && (sel == VIW'(v));
    end
  end

  assign drop = flit_in[21] && (push_en == '0);

  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VC; v++) begin
      if (push_en[v]) mem[v][tail[v]] <= flit_in[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < NUM_VC; v++) begin
        head[v]  <= '0;
        tail[v]  <= '0;
        count[v] <= '0;
      end
      rr_ptr   <= '0;
      cr_out   <= '0;
      overflow <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (push_en[v]) tail[v] <= ptr_inc(tail[v]);
        if (pop_en[v])  head[v] <= ptr_inc(head[v]);
        if (push_en[v] && !pop_en[v])      count[v] <= count[v] + 1'b1;
        else if (pop_en[v] && !push_en[v]) count[v] <= count[v] - 1'b1;
      end
      if (pop) begin
        rr_ptr <= (int'(sel) == NUM_VC - 1) ? '0 : sel + 1'b1;
        cr_out <= {1'b1, 5'(sel), in_cycle};
      end else begin
        cr_out <= '0;
      end
      overflow <= overflow | drop;
    end
  end

  generate
    for (genvar g = 0; g < NUM_VC; g++) begin : g_occ
      assign occupancy[g*4 +: 4] = 4'(count[g]);
    end
  endgenerate

endmodule
`default_nettype wire
